spi_master_cfg: RTL and testbench

- Parametrised SPI master: DATA_W-bit full-duplex frames, programmable SCK divider, all four SPI modes selectable per frame, NUM_CS one-hot chip selects.
- Controlled by a start/busy/done handshake from the host logic.
- Sits between the on-chip controller and external SPI slaves; replaces the fixed 8-bit, single-select master.

---
 rtl/spi_master_cfg.sv | 165 ++++++++++++++++
 tb/tb_spi_master_cfg.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - parametrised SPI master, four modes, one-hot selects; option macro SPI_MASTER_LSB_FIRST_EN
module spi_master_cfg #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4,
   parameter int NUM_CS  = 2,
   parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [CS_W-1:0]   cs_sel,
`ifdef SPI_MASTER_LSB_FIRST_EN
   input  logic              lsb_first,
`endif
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sck,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;
   logic              cpol_l;
   logic              cpha_l;
   logic              lsb_l;
   logic              lsb_in;

   logic              half_end;
   logic              leading;
   logic              sample_now;
   logic              shift_now;
   logic              last_edge;
   logic [BIT_W-1:0]  bit_cnt_nxt;
   logic [DIV_W-1:0]  div_cnt_nxt;
   logic [DATA_W-1:0] rx_sr_nxt;
   logic              tx_bit;
   logic [DATA_W-1:0] tx_sr_nxt;
   logic              first_bit;
   logic [DATA_W-1:0] first_rest;
   logic [NUM_CS-1:0] cs_dec;

`ifdef SPI_MASTER_LSB_FIRST_EN
   assign lsb_in = lsb_first;
`else
   assign lsb_in = 1'b0;
`endif

   // Edge classification: an SCK edge is leading when SCK currently sits at its idle level.
   always_comb begin
      half_end    = (div_cnt == DIV_LAST);
      div_cnt_nxt = half_end ? '0 : div_cnt + DIV_W'(1);
      leading     = (sck == cpol_l);
      sample_now  = half_end && (leading != cpha_l);
      shift_now   = half_end && (leading == cpha_l);
      bit_cnt_nxt = bit_cnt + BIT_W'(sample_now);
      // The final edge of a frame is always a trailing edge once all bits are sampled
      last_edge   = half_end && !leading && (bit_cnt_nxt == BIT_LAST);
      rx_sr_nxt   = lsb_l ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
      tx_bit      = lsb_l ? tx_sr[0] : tx_sr[DATA_W-1];
      tx_sr_nxt   = lsb_l ? (tx_sr >> 1) : (tx_sr << 1);
      first_bit   = lsb_in ? tx_data[0] : tx_data[DATA_W-1];
      first_rest  = lsb_in ? (tx_data >> 1) : (tx_data << 1);
   end

   // One-hot active-low select decode; out-of-range indices select nothing.
   always_comb begin
      cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
      end
   end

   // Frame sequencer: IDLE -> SETUP -> XFER -> HOLD, all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         cpol_l  <= 1'b0;
         cpha_l  <= 1'b0;
         lsb_l   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rx_data <= '0;
         sck     <= 1'b0;
         mosi    <= 1'b0;
         cs_n    <= '1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               sck  <= cpol;
               mosi <= 1'b0;
               cs_n <= '1;
               if (start) begin
                  state   <= SETUP;
                  busy    <= 1'b1;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  rx_sr   <= '0;
                  cpol_l  <= cpol;
                  cpha_l  <= cpha;
                  lsb_l   <= lsb_in;
                  cs_n    <= cs_dec;
                  // With cpha=0 the first bit must be on the line before the first leading edge
                  if (!cpha) begin
                     mosi  <= first_bit;
                     tx_sr <= first_rest;
                  end else begin
                     tx_sr <= tx_data;
                  end
               end
            end
            SETUP: begin
               div_cnt <= div_cnt_nxt;
               if (half_end) state <= XFER;
            end
            XFER: begin
               div_cnt <= div_cnt_nxt;
               if (half_end) sck <= ~sck;
               if (sample_now) begin
                  rx_sr   <= rx_sr_nxt;
                  bit_cnt <= bit_cnt_nxt;
               end
               if (shift_now) begin
                  mosi  <= tx_bit;
                  tx_sr <= tx_sr_nxt;
               end
               if (last_edge) state <= HOLD;
            end
            HOLD: begin
               div_cnt <= div_cnt_nxt;
               sck     <= cpol_l;
               if (half_end) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  cs_n    <= '1;
                  rx_data <= rx_sr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb/tb_spi_master_cfg.sv - randomized self-checking bench for spi_master_cfg with behavioural SPI slave
module tb_spi_master_cfg;

   localparam int DW  = 8;
   localparam int CD  = 2;
   localparam int NCS = 3;
   localparam int LAT = 1 + (2 * DW + 2) * CD;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [DW-1:0]  tx_data = '0;
   logic           cpol = 1'b0;
   logic           cpha = 1'b0;
   logic [1:0]     cs_sel = '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
   logic           lsb_first = 1'b0;
`endif
   logic           busy;
   logic           done;
   logic [DW-1:0]  rx_data;
   logic           sck;
   logic           mosi;
   logic           miso;
   logic [NCS-1:0] cs_n;

   int n_cmp = 0;
   int n_err = 0;

   // frame description handed to the slave model
   logic          f_cpol = 1'b0;
   logic          f_cpha = 1'b0;
   logic          f_lsb = 1'b0;
   logic [DW-1:0] s_word = '0;

   // slave model observations for the current frame
   logic [DW-1:0] m_mosi;
   int            m_samples;
   int            m_edges;

   spi_master_cfg #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(NCS)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .tx_data(tx_data),
      .cpol(cpol),
      .cpha(cpha),
      .cs_sel(cs_sel),
`ifdef SPI_MASTER_LSB_FIRST_EN
      .lsb_first(lsb_first),
`endif
      .busy(busy),
      .done(done),
      .rx_data(rx_data),
      .sck(sck),
      .mosi(mosi),
      .miso(miso),
      .cs_n(cs_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int bitpos(input int k, input logic lsb);
      return lsb ? k : (DW - 1 - k);
   endfunction

   // Behavioural SPI slave: drives miso on shift edges, captures mosi on sample edges
   initial begin : slave_model
      logic          prev_busy;
      logic          prev_sck;
      logic          pol, pha, lsb;
      logic [DW-1:0] sw;
      int            sidx;
      prev_busy = 1'b0;
      prev_sck  = 1'b0;
      miso      = 1'b0;
      m_mosi    = '0;
      m_samples = 0;
      m_edges   = 0;
      sidx      = 0;
      pol = 1'b0; pha = 1'b0; lsb = 1'b0; sw = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_busy = 1'b0;
         end else begin
            if (busy && !prev_busy) begin
               pol = f_cpol; pha = f_cpha; lsb = f_lsb; sw = s_word;
               m_mosi = '0; m_samples = 0; m_edges = 0; sidx = 0;
               if (!pha) begin
                  miso = sw[bitpos(0, lsb)];
                  sidx = 1;
               end else begin
                  miso = 1'($urandom_range(0, 1));
               end
            end else if (busy && (sck != prev_sck)) begin
               m_edges++;
               if ((prev_sck == pol) != pha) begin
                  if (m_samples < DW) m_mosi[bitpos(m_samples, lsb)] = mosi;
                  m_samples++;
               end else if (sidx < DW) begin
                  miso = sw[bitpos(sidx, lsb)];
                  sidx++;
               end
            end
            prev_busy = busy;
         end
         prev_sck = sck;
      end
   end

   task automatic do_frame(input logic [7:0] tx, input logic pol, input logic pha,
                           input logic [1:0] sel, input logic [7:0] sw, input logic lsb,
                           input bit scramble);
      logic [2:0] exp_cs;
      int         got;
      exp_cs = (sel < 3) ? ~(3'b001 << sel) : 3'b111;
      got = 0;
      @(negedge clk);
      cpol = pol; cpha = pha; cs_sel = sel; tx_data = tx;
`ifdef SPI_MASTER_LSB_FIRST_EN
      lsb_first = lsb;
`endif
      f_cpol = pol; f_cpha = pha; f_lsb = lsb; s_word = sw;
      @(negedge clk);
      chk("sck_idle", 32'(sck), 32'(pol));
      start = 1'b1;
      for (int i = 1; i <= LAT + 20; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0;
            chk("busy_on", 32'(busy), 32'd1);
            chk("cs_frame", 32'(cs_n), 32'(exp_cs));
            chk("sck_setup", 32'(sck), 32'(pol));
         end
         if (scramble && i == 5) begin
            tx_data = 8'($urandom);
            cpol = ~pol; cpha = ~pha; cs_sel = ~sel;
            start = 1'b1;
         end
         if (scramble && i == 6) start = 1'b0;
         if (i == LAT - 1) chk("cs_hold", 32'(cs_n), 32'(exp_cs));
         if (done) begin
            got = i;
            break;
         end
      end
      #1;
      chk("latency", 32'(got), 32'(LAT));
      chk("busy_off", 32'(busy), 32'd0);
      chk("cs_release", 32'(cs_n), 32'h7);
      chk("rx_data", 32'(rx_data), 32'(sw));
      chk("mosi_word", 32'(m_mosi), 32'(tx));
      chk("sample_cnt", 32'(m_samples), 32'(DW));
      chk("edge_cnt", 32'(m_edges), 32'(2 * DW));
      @(negedge clk);
      chk("no_requeue", 32'(busy), 32'd0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int  n_done;
      bit  seen_done;
      logic lsb_r;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_sck", 32'(sck), 32'd0);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_cs", 32'(cs_n), 32'h7);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rx", 32'(rx_data), 32'd0);
      rst_n = 1'b1;

      // the four SPI modes with the reference frame
      do_frame(8'hA5, 1'b0, 1'b0, 2'd1, 8'h3C, 1'b0, 1'b0);
      do_frame(8'hA5, 1'b0, 1'b1, 2'd1, 8'h3C, 1'b0, 1'b0);
      do_frame(8'hA5, 1'b1, 1'b0, 2'd1, 8'h3C, 1'b0, 1'b0);
      do_frame(8'hA5, 1'b1, 1'b1, 2'd1, 8'h3C, 1'b0, 1'b0);

      // invalid select still runs a full frame
      do_frame(8'hFF, 1'b0, 1'b0, 2'd3, 8'h5A, 1'b0, 1'b0);

      // back-to-back with start held high across done
      @(negedge clk);
      cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd0; tx_data = 8'h01;
`ifdef SPI_MASTER_LSB_FIRST_EN
      lsb_first = 1'b0;
`endif
      f_cpol = 1'b0; f_cpha = 1'b0; f_lsb = 1'b0; s_word = 8'h3C;
      @(negedge clk);
      start = 1'b1;
      n_done = 0;
      for (int i = 1; i <= 3 * LAT; i++) begin
         @(negedge clk);
         if (i == 2) tx_data = 8'h80;
         if (i == LAT + 2) start = 1'b0;
         if (i == LAT - 1 || i == LAT + 1) chk("b2b_cs_low", 32'(cs_n), 32'h6);
         if (done) begin
            #1;
            n_done++;
            chk("b2b_cs_gap", 32'(cs_n), 32'h7);
            chk("b2b_rx", 32'(rx_data), 32'h3C);
            chk("b2b_mosi", 32'(m_mosi), (n_done == 1) ? 32'h01 : 32'h80);
            chk("b2b_at", 32'(i), 32'(n_done * LAT));
         end
      end
      chk("b2b_count", 32'(n_done), 32'd2);

      // reset in the middle of a frame
      @(negedge clk);
      cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd0; tx_data = 8'hC3;
      f_cpol = 1'b0; f_cpha = 1'b0; f_lsb = 1'b0; s_word = 8'h96;
      @(negedge clk);
      start = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
      end
      chk("pre_rst_cs", 32'(cs_n), 32'h6);
      rst_n = 1'b0;
      #1;
      chk("arst_cs", 32'(cs_n), 32'h7);
      chk("arst_sck", 32'(sck), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_rx", 32'(rx_data), 32'd0);
      seen_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (LAT) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      chk("arst_no_done", 32'(seen_done), 32'd0);
      chk("arst_rx_hold", 32'(rx_data), 32'd0);
      do_frame(8'h3E, 1'b0, 1'b0, 2'd2, 8'hC1, 1'b0, 1'b0);

`ifdef SPI_MASTER_LSB_FIRST_EN
      // LSB-first frame
      do_frame(8'h01, 1'b0, 1'b0, 2'd0, 8'h80, 1'b1, 1'b0);
`endif

      // randomized frames with input disturbance while busy
      repeat (8) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
         lsb_r = 1'($urandom_range(0, 1));
`else
         lsb_r = 1'b0;
`endif
         do_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 8'($urandom), lsb_r, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
